// File: rtl/motor_ramp_pkg.sv
// Shared types and default constants for the motor ramp sequencer.
// Imported by the sequencer top and its step unit.
package motor_ramp_pkg;

   typedef enum logic {
      IDLE,
      SWEEP
   } state_t;

   localparam int DEF_CHANNELS   = 5;
   localparam int DEF_POS_WIDTH  = 10;
   localparam int DEF_STEP_WIDTH = 8;
   localparam int DEF_INIT_POS   = 512;

   // Bits needed to index n channels (never zero).
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/motor_ramp_step.sv
// Combinational clamp/step unit, shared by all channels of the sweep.
// Moves pos toward target by step without overshooting.
module motor_ramp_step
   import motor_ramp_pkg::*;
#(
   parameter int POS_WIDTH  = DEF_POS_WIDTH,
   parameter int STEP_WIDTH = DEF_STEP_WIDTH
) (
   input  logic [POS_WIDTH-1:0]  pos,
   input  logic [POS_WIDTH-1:0]  target,
   input  logic [STEP_WIDTH-1:0] step,
   output logic [POS_WIDTH-1:0]  next_pos
);

   localparam int W =
      ((POS_WIDTH > STEP_WIDTH) ? POS_WIDTH : STEP_WIDTH) + 1;

   logic [W-1:0] pe;
   logic [W-1:0] te;
   logic [W-1:0] se;

   assign pe = W'(pos);
   assign te = W'(target);
   assign se = W'(step);

   // Distance to target decides between a full step and a clamp.
   always_comb begin
      next_pos = pos;
      if (step == '0) begin
         next_pos = target;
      end else if (pos < target) begin
         if (se >= te - pe) next_pos = target;
         else               next_pos = POS_WIDTH'(pe + se);
      end else if (pos > target) begin
         if (se >= pe - te) next_pos = target;
         else               next_pos = POS_WIDTH'(pe - se);
      end
   end

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Slew-rate scheduler: per-tick round-robin sweep of one step unit
// across all channels, with a command port for targets and steps.
module motor_ramp_sequencer
   import motor_ramp_pkg::*;
#(
   parameter int CHANNELS   = DEF_CHANNELS,
   parameter int POS_WIDTH  = DEF_POS_WIDTH,
   parameter int STEP_WIDTH = DEF_STEP_WIDTH,
   parameter int TICK_DIV   = 50000,
   parameter int INIT_POS   = DEF_INIT_POS
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset_n,
   input  logic                          enable,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [2:0]                    cmd_ch,
   input  logic [POS_WIDTH-1:0]          cmd_target,
   input  logic [STEP_WIDTH-1:0]         cmd_step,
   output logic [CHANNELS*POS_WIDTH-1:0] pos_out,
   output logic [CHANNELS-1:0]           busy,
   output logic                          done,
   output logic                          cmd_err,
   output logic                          overrun
);

   localparam int CW    = ch_width(CHANNELS);
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [POS_WIDTH-1:0] RST_POS = POS_WIDTH'(INIT_POS);
   localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

   state_t                state;
   logic [CW-1:0]         idx;
   logic [CNT_W-1:0]      cnt;
   logic                  tick;
   logic                  accept;
   logic                  ch_ok;
   logic [POS_WIDTH-1:0]  pos_q  [CHANNELS];
   logic [POS_WIDTH-1:0]  tgt_q  [CHANNELS];
   logic [STEP_WIDTH-1:0] step_q [CHANNELS];
   logic [POS_WIDTH-1:0]  pos_n  [CHANNELS];
   logic [POS_WIDTH-1:0]  tgt_n  [CHANNELS];
   logic [STEP_WIDTH-1:0] step_n [CHANNELS];
   logic [CHANNELS-1:0]   busy_n;
   logic [POS_WIDTH-1:0]  sel_pos;
   logic [POS_WIDTH-1:0]  sel_tgt;
   logic [STEP_WIDTH-1:0] sel_step;
   logic [POS_WIDTH-1:0]  next_pos;

   assign tick      = enable && (cnt == CNT_W'(TICK_DIV - 1));
   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign ch_ok     = ({1'b0, cmd_ch} < 4'(CHANNELS));

   // Free-running tick divider, parked at zero while disabled.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n)      cnt <= '0;
      else if (!enable || tick) cnt <= '0;
      else                      cnt <= cnt + CNT_W'(1);
   end

   // Route the channel under sweep into the shared step unit.
   always_comb begin
      sel_pos  = pos_q[0];
      sel_tgt  = tgt_q[0];
      sel_step = step_q[0];
      for (int i = 0; i < CHANNELS; i++) begin
         if (idx == CW'(i)) begin
            sel_pos  = pos_q[i];
            sel_tgt  = tgt_q[i];
            sel_step = step_q[i];
         end
      end
   end

   motor_ramp_step #(
      .POS_WIDTH  (POS_WIDTH),
      .STEP_WIDTH (STEP_WIDTH)
   ) u_step (
      .pos      (sel_pos),
      .target   (sel_tgt),
      .step     (sel_step),
      .next_pos (next_pos)
   );

   // Next channel state: command writes in IDLE, one step in SWEEP.
   always_comb begin
      pos_n  = pos_q;
      tgt_n  = tgt_q;
      step_n = step_q;
      busy_n = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (accept && ch_ok && cmd_ch == 3'(i)) begin
            tgt_n[i]  = cmd_target;
            step_n[i] = cmd_step;
         end
         if (state == SWEEP && idx == CW'(i)) begin
            pos_n[i] = next_pos;
         end
         busy_n[i] = (pos_n[i] != tgt_n[i]);
      end
   end

   // Channel registers, busy flags and the settle pulse.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            pos_q[i]  <= RST_POS;
            tgt_q[i]  <= RST_POS;
            step_q[i] <= '0;
         end
         busy <= '0;
         done <= 1'b0;
      end else begin
         pos_q  <= pos_n;
         tgt_q  <= tgt_n;
         step_q <= step_n;
         busy   <= busy_n;
         done   <= (|busy) && !(|busy_n);
      end
   end

   // Sweep sequencer with error and sticky overrun flags.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state   <= IDLE;
         idx     <= '0;
         overrun <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         cmd_err <= accept && !ch_ok;
         unique case (state)
            IDLE: begin
               if (tick) begin
                  state <= SWEEP;
                  idx   <= '0;
               end
            end
            SWEEP: begin
               if (tick) overrun <= 1'b1;
               if (idx == LAST) begin
                  state <= IDLE;
                  idx   <= '0;
               end else begin
                  idx <= idx + CW'(1);
               end
            end
         endcase
      end
   end

   // Flatten channel positions onto the output bus.
   always_comb begin
      pos_out = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         pos_out[i*POS_WIDTH +: POS_WIDTH] = pos_q[i];
      end
   end

endmodule

// File: doc/motor_ramp_sequencer.md
Name: motor_ramp_sequencer

Overview:
Slew-rate scheduler for the five servo/motor channels driven by the motor controller core. It accepts per-channel target positions and step sizes from the SCI command decoder. On each update tick it sweeps one shared step unit across all channels, round-robin, one channel per clock. The 10-bit position outputs feed the per-channel PWM generators directly.

Parameters:
CHANNELS, 5, number of motor channels (1..8)
POS_WIDTH, 10, position/target width in bits
STEP_WIDTH, 8, per-channel step size width
TICK_DIV, 50000, clk cycles per update tick (1 ms at 50 MHz); must be > CHANNELS+1
INIT_POS, 512, reset value of every position and target (servo centre)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  synchronous, active-low reset
enable  in  1  1 = tick counter runs; 0 = hold all positions
cmd_valid  in  1  command strobe
cmd_ready  out  1  block can accept a command this cycle
cmd_ch  in  3  target channel index, 0-based
cmd_target  in  POS_WIDTH  new target position
cmd_step  in  STEP_WIDTH  new step per tick; 0 = jump immediately
pos_out  out  CHANNELS*POS_WIDTH  current positions; ch i at bits [i*POS_WIDTH +: POS_WIDTH]
busy  out  CHANNELS  bit i = 1 while pos[i] != target[i]
done  out  1  one-cycle pulse when busy goes from nonzero to all-zero
cmd_err  out  1  one-cycle pulse when an accepted command has cmd_ch >= CHANNELS
overrun  out  1  sticky: a tick arrived while a sweep was in progress

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is synchronous and active-low on reset_reset_n; it is sampled only on the rising edge of clk_clk.
- Reset values: pos = target = INIT_POS for every channel; step = 0; tick counter = 0; FSM = IDLE; busy = 0; done = 0; cmd_err = 0; overrun = 0; cmd_ready = 1.
- Reset mid-sweep: aborts the sweep and restores all reset values.
- Tick counter: counts 0..TICK_DIV-1 while enable = 1. Wrapping to 0 produces a single-cycle tick.
- enable = 0: the counter is held at 0 and no ticks occur. Commands are still accepted.
- FSM states and transitions:
  - IDLE: on tick, go to SWEEP with channel index 0.
  - SWEEP: update channel idx, then increment idx. After idx = CHANNELS-1, return to IDLE.
  - A sweep always lasts exactly CHANNELS cycles.
- Command handshake: cmd_ready = 1 only in IDLE. A command is accepted when cmd_valid and cmd_ready are both 1; target[cmd_ch] and step[cmd_ch] are written that cycle.
- Invalid channel: if cmd_ch >= CHANNELS, the command is still accepted, nothing is written, and cmd_err pulses the next cycle.
- Command and tick in the same IDLE cycle: the write happens first. The sweep starting next cycle uses the new target and step.
- Step rule, one channel per SWEEP cycle. Compute in POS_WIDTH+1 bits so the result never wraps.
  - step = 0: pos = target.
  - pos < target: pos = min(pos+step, target).
  - pos > target: pos = max(pos-step, target).
  - pos = target: no change.
- Timing: tick asserted in cycle T → channel k is computed in cycle T+1+k and its new value is visible on pos_out in cycle T+2+k.
- busy is registered from pos != target and is updated on every write and every step.
- done pulses the cycle after busy transitions from nonzero to zero.
- Tick during SWEEP: the tick is dropped and overrun is set. overrun clears only on reset.

Decomposition:
- Package motor_ramp_pkg:
  - FSM state enum {IDLE, SWEEP}
  - default constants: CHANNELS, POS_WIDTH, STEP_WIDTH, INIT_POS
  - channel-index width function
- Sub-module motor_ramp_step: purely combinational clamp/step unit (pos, target, step → next_pos). It is instantiated once and time-shared across channels by the sweep.

Test Plan:
- Reset: hold reset_reset_n low for 3 clocks → every pos_out field reads 512; busy = 0; cmd_ready = 1; overrun = 0.
- Upward ramp: TICK_DIV = 10, write ch0 target 600 step 20 → ch0 sequence 532, 552, 572, 592, 600 on successive ticks; done pulses once after 600; other channels stay 512.
- Downward ramp and jump:
  - ch2 target 500 step 7 → 505, 500, with the clamp holding at 500.
  - ch3 target 1023 step 0 → 1023 after the first tick.
- Command coincident with tick: assert cmd_valid on the tick cycle for ch4 target 520 step 8 → ch4 reads 520 at T+6.
- Invalid channel and enable: cmd_ch = 6 → cmd_err pulses and no field changes. With enable = 0 for 5×TICK_DIV cycles → positions are frozen, and a pending target resumes ramping after enable returns to 1.
- Overrun: TICK_DIV = 4 with CHANNELS = 5 → overrun goes to 1 and stays 1 until reset; every sweep still completes all 5 channels.
